mmram_match_unit: RTL and testbench
===================================

MMRAM_MATCH_UNIT -- requirements
Module: mmram_match_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand width.
REQ-002 SHALL have parameter COLOR_W, default 3, meaning color tag width.
REQ-003 SHALL have parameter GEN_W, default 8, meaning generation tag width.
REQ-004 SHALL have parameter DEST_W, default 7, meaning destination node width.
REQ-005 SHALL have parameter ADDR_W, default 6, meaning matching-memory depth of 2^ADDR_W entries.
REQ-006 SHALL have ports CLK in 1 (single clock, rising edge) and MR_N in 1 (reset, asynchronous, active-low).
REQ-007 SHALL have ports Send_in in 1 (input packet valid) and Ack_out out 1 (input ready).
REQ-008 SHALL have input packet ports COLOR_IN (COLOR_W), GEN_IN (GEN_W), DEST_IN (DEST_W), LR_IN (1; 0=left, 1=right), MATCH_IN (1; 1=needs partner), DATA_IN (DATA_W), ADDR_IN (ADDR_W) and DEL_IN (1; delete entry).
REQ-009 SHALL have port FLUSH in 1, meaning invalidate all entries.
REQ-010 SHALL have ports Send_out out 1 (output valid) and Ack_in in 1 (downstream ready).
REQ-011 SHALL have output packet ports COLOR_OUT, GEN_OUT, DEST_OUT, PAIR_OUT (1), ERR_OUT (1), DATAL_OUT (DATA_W) and DATAR_OUT (DATA_W).
REQ-012 SHALL have status ports OCC out ADDR_W+1 (valid entry count) and COLL_CNT out 16 (collision count).

Function
REQ-013 Input accepted on a CLK edge iff Send_in && Ack_out; Ack_out = !FLUSH && (!Send_out || Ack_in).
REQ-014 Memory entry = {valid, color, gen, dest, lr, data}; only valid bits are reset or flushed.
REQ-015 Accepted DEL_IN=1: clear valid[ADDR_IN], decrement OCC if it was set, emit nothing; other fields ignored.
REQ-016 Accepted MATCH_IN=0: emit packet next cycle, PAIR_OUT=0, ERR_OUT=0, DATAL_OUT=DATA_IN, DATAR_OUT=0; memory untouched.
REQ-017 MATCH_IN=1, entry invalid: write entry, set valid, OCC+1, emit nothing.
REQ-018 MATCH_IN=1, entry valid, {color,gen,dest} equal, lr opposite: emit pair with PAIR_OUT=1; left operand on DATAL_OUT, right on DATAR_OUT; clear valid; OCC-1.
REQ-019 MATCH_IN=1, entry valid, tag mismatch or same lr: emit incoming packet unchanged with ERR_OUT=1, PAIR_OUT=0, DATAL_OUT=DATA_IN; entry kept; COLL_CNT+1, saturating at 16'hFFFF.
REQ-020 Output latency SHALL be exactly 1 cycle from acceptance; output fields held stable while Send_out && !Ack_in.
REQ-021 Send_out clears on Ack_in unless a new emitting packet is accepted the same edge (back-to-back throughput 1/cycle).
REQ-022 Back-to-back accesses to the same ADDR_IN SHALL see the previous cycle's update (no read hazard).
REQ-023 FLUSH=1 on an edge clears all valid bits and OCC; accepts nothing; pending output unaffected.
REQ-024 OCC never exceeds 2^ADDR_W; write to an invalid entry with OCC full cannot occur by construction.

Reset
REQ-025 MR_N low asynchronously forces Send_out=0, all valid bits=0, OCC=0, COLL_CNT=0, ERR_OUT=0, PAIR_OUT=0.
REQ-026 Ack_out SHALL be 0 while MR_N low; operation resumes the first edge after MR_N rises.
REQ-027 Reset mid-operation discards any unacknowledged output and all stored operands.

Verification
REQ-028 Left {c0,g0,d4,data 0x0055} at addr 3, then right {c0,g0,d4,0x007F} at addr 3 -> one output PAIR_OUT=1, DATAL=0x0055, DATAR=0x007F, OCC 1->0.
REQ-029 MATCH_IN=0 data 0x0040, Ack_in=1 -> Send_out high next cycle, DATAL=0x0040, DATAR=0, OCC unchanged.
REQ-030 Left {c0,...} at addr 5, then left {c1,...} at addr 5 -> second emitted ERR_OUT=1, COLL_CNT=1, entry still c0, OCC=1.
REQ-031 Ack_in=0 with output pending, Send_in held -> Ack_out=0, output stable; Ack_in=1 -> next packet accepted same edge.
REQ-032 Store at addrs 3,4,5 then FLUSH one cycle -> OCC=0; right operand at addr 4 stored, not paired.
REQ-033 MR_N pulsed low while Send_out=1 -> Send_out=0 immediately, OCC=0, COLL_CNT=0.

Source files
------------

// File: rtl/mmram_match_unit_if.sv
// Packet handshake bundle for the matching unit.
// Carries both the input stream and the emitted output stream.
interface mmram_match_unit_if #(
  parameter int DATA_W  = 16,
  parameter int COLOR_W = 3,
  parameter int GEN_W   = 8,
  parameter int DEST_W  = 7,
  parameter int ADDR_W  = 6
);
  logic               Send_in;
  logic               Ack_out;
  logic [COLOR_W-1:0] COLOR_IN;
  logic [GEN_W-1:0]   GEN_IN;
  logic [DEST_W-1:0]  DEST_IN;
  logic               LR_IN;
  logic               MATCH_IN;
  logic [DATA_W-1:0]  DATA_IN;
  logic [ADDR_W-1:0]  ADDR_IN;
  logic               DEL_IN;

  logic               Send_out;
  logic               Ack_in;
  logic [COLOR_W-1:0] COLOR_OUT;
  logic [GEN_W-1:0]   GEN_OUT;
  logic [DEST_W-1:0]  DEST_OUT;
  logic               PAIR_OUT;
  logic               ERR_OUT;
  logic [DATA_W-1:0]  DATAL_OUT;
  logic [DATA_W-1:0]  DATAR_OUT;

  modport master (
    output Send_in, COLOR_IN, GEN_IN, DEST_IN,
    output LR_IN, MATCH_IN, DATA_IN, ADDR_IN,
    output DEL_IN, Ack_in,
    input  Ack_out, Send_out, COLOR_OUT, GEN_OUT,
    input  DEST_OUT, PAIR_OUT, ERR_OUT,
    input  DATAL_OUT, DATAR_OUT
  );

  modport slave (
    input  Send_in, COLOR_IN, GEN_IN, DEST_IN,
    input  LR_IN, MATCH_IN, DATA_IN, ADDR_IN,
    input  DEL_IN, Ack_in,
    output Ack_out, Send_out, COLOR_OUT, GEN_OUT,
    output DEST_OUT, PAIR_OUT, ERR_OUT,
    output DATAL_OUT, DATAR_OUT
  );
endinterface

// File: rtl/mmram_match_unit.sv
// Dataflow operand matching memory: pairs left/right tokens by tag.
// Single-cycle lookup, one registered output slot with valid/ready.
module mmram_match_unit #(
  parameter int DATA_W  = 16,
  parameter int COLOR_W = 3,
  parameter int GEN_W   = 8,
  parameter int DEST_W  = 7,
  parameter int ADDR_W  = 6
) (
  input  logic              CLK,
  input  logic              MR_N,
  input  logic              FLUSH,
  mmram_match_unit_if.slave bus,
  output logic [ADDR_W:0]   OCC,
  output logic [15:0]       COLL_CNT
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]   valid;
  logic [COLOR_W-1:0] mem_color [DEPTH];
  logic [GEN_W-1:0]   mem_gen   [DEPTH];
  logic [DEST_W-1:0]  mem_dest  [DEPTH];
  logic               mem_lr    [DEPTH];
  logic [DATA_W-1:0]  mem_data  [DEPTH];

  logic               send_q;
  logic [COLOR_W-1:0] color_q;
  logic [GEN_W-1:0]   gen_q;
  logic [DEST_W-1:0]  dest_q;
  logic               pair_q;
  logic               err_q;
  logic [DATA_W-1:0]  datal_q;
  logic [DATA_W-1:0]  datar_q;

  logic              accept;
  logic              hit;
  logic              tag_eq;
  logic              do_del;
  logic              do_pass;
  logic              do_store;
  logic              do_pair;
  logic              do_coll;
  logic              emit;
  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] datal_n;
  logic [DATA_W-1:0] datar_n;

  assign bus.Ack_out = MR_N && !FLUSH
                     && (!send_q || bus.Ack_in);

  // Async-read memory: a same-address access on the
  // next edge already sees this edge's write.
  always_comb begin
    accept   = bus.Send_in && bus.Ack_out;
    hit      = valid[bus.ADDR_IN];
    stored   = mem_data[bus.ADDR_IN];
    tag_eq   = (mem_color[bus.ADDR_IN] == bus.COLOR_IN)
            && (mem_gen[bus.ADDR_IN] == bus.GEN_IN)
            && (mem_dest[bus.ADDR_IN] == bus.DEST_IN);
    do_del   = accept && bus.DEL_IN;
    do_pass  = accept && !bus.DEL_IN && !bus.MATCH_IN;
    do_store = accept && !bus.DEL_IN && bus.MATCH_IN
            && !hit;
    do_pair  = accept && !bus.DEL_IN && bus.MATCH_IN
            && hit && tag_eq
            && (mem_lr[bus.ADDR_IN] != bus.LR_IN);
    do_coll  = accept && !bus.DEL_IN && bus.MATCH_IN
            && hit && !do_pair;
    emit     = do_pass || do_pair || do_coll;
    datal_n  = bus.DATA_IN;
    datar_n  = '0;
    if (do_pair) begin
      datal_n = bus.LR_IN ? stored : bus.DATA_IN;
      datar_n = bus.LR_IN ? bus.DATA_IN : stored;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_store) begin
      mem_color[bus.ADDR_IN] <= bus.COLOR_IN;
      mem_gen[bus.ADDR_IN]   <= bus.GEN_IN;
      mem_dest[bus.ADDR_IN]  <= bus.DEST_IN;
      mem_lr[bus.ADDR_IN]    <= bus.LR_IN;
      mem_data[bus.ADDR_IN]  <= bus.DATA_IN;
    end
  end

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      valid <= '0;
      OCC   <= '0;
    end else if (FLUSH) begin
      valid <= '0;
      OCC   <= '0;
    end else if (do_store) begin
      valid[bus.ADDR_IN] <= 1'b1;
      OCC                <= OCC + 1'b1;
    end else if (do_pair || (do_del && hit)) begin
      valid[bus.ADDR_IN] <= 1'b0;
      OCC                <= OCC - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      COLL_CNT <= '0;
    end else if (do_coll && COLL_CNT != 16'hFFFF) begin
      COLL_CNT <= COLL_CNT + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      send_q  <= 1'b0;
      color_q <= '0;
      gen_q   <= '0;
      dest_q  <= '0;
      pair_q  <= 1'b0;
      err_q   <= 1'b0;
      datal_q <= '0;
      datar_q <= '0;
    end else if (emit) begin
      send_q  <= 1'b1;
      color_q <= bus.COLOR_IN;
      gen_q   <= bus.GEN_IN;
      dest_q  <= bus.DEST_IN;
      pair_q  <= do_pair;
      err_q   <= do_coll;
      datal_q <= datal_n;
      datar_q <= datar_n;
    end else if (bus.Ack_in) begin
      send_q  <= 1'b0;
    end
  end

  assign bus.Send_out  = send_q;
  assign bus.COLOR_OUT = color_q;
  assign bus.GEN_OUT   = gen_q;
  assign bus.DEST_OUT  = dest_q;
  assign bus.PAIR_OUT  = pair_q;
  assign bus.ERR_OUT   = err_q;
  assign bus.DATAL_OUT = datal_q;
  assign bus.DATAR_OUT = datar_q;
endmodule

// File: tb/tb_mmram_match_unit.sv
// Bench for mmram_match_unit: directed table, corner
// sequences, then random traffic against a token model.
module tb_mmram_match_unit;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [6:0]  occ;
  logic [15:0] coll;

  mmram_match_unit_if bus();

  mmram_match_unit dut (
    .CLK(clk), .MR_N(rst_n), .FLUSH(flush),
    .bus(bus), .OCC(occ), .COLL_CNT(coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit          mv [64];
  logic [2:0]  mc [64];
  logic [7:0]  mg [64];
  logic [6:0]  md [64];
  bit          ml [64];
  logic [15:0] mdat [64];
  int          m_occ;
  int          m_coll;
  bit          m_send;
  logic [22:0] e_tag;
  logic [15:0] e_l;
  logic [15:0] e_r;

  function void chk(string n, logic [31:0] a,
                    logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  task automatic drive(bit snd, bit del, bit mat,
      bit lr, logic [2:0] c, logic [7:0] g,
      logic [6:0] d, logic [5:0] a,
      logic [15:0] data, bit ack, bit fl);
    bus.Send_in  = snd;
    bus.DEL_IN   = del;
    bus.MATCH_IN = mat;
    bus.LR_IN    = lr;
    bus.COLOR_IN = c;
    bus.GEN_IN   = g;
    bus.DEST_IN  = d;
    bus.ADDR_IN  = a;
    bus.DATA_IN  = data;
    bus.Ack_in   = ack;
    flush        = fl;
  endtask

  function void model_reset();
    mv = '{default: 0};
    m_occ = 0;
    m_coll = 0;
    m_send = 0;
  endfunction

  function bit model_ack();
    return !flush && (!m_send || bus.Ack_in);
  endfunction

  // Token-store semantics: one slot per address.
  function void model_edge();
    bit emit;
    int a;
    emit = 0;
    a = int'(bus.ADDR_IN);
    if (flush) begin
      mv = '{default: 0};
      m_occ = 0;
    end else if (bus.Send_in && model_ack()) begin
      e_tag = {bus.COLOR_IN, bus.GEN_IN, bus.DEST_IN,
               1'b0, 1'b0};
      if (bus.DEL_IN) begin
        if (mv[a]) begin
          mv[a] = 0;
          m_occ--;
        end
      end else if (!bus.MATCH_IN) begin
        emit = 1;
        e_l = bus.DATA_IN;
        e_r = 0;
      end else if (!mv[a]) begin
        mv[a] = 1;
        mc[a] = bus.COLOR_IN;
        mg[a] = bus.GEN_IN;
        md[a] = bus.DEST_IN;
        ml[a] = bus.LR_IN;
        mdat[a] = bus.DATA_IN;
        m_occ++;
      end else if (mc[a] == bus.COLOR_IN &&
                   mg[a] == bus.GEN_IN &&
                   md[a] == bus.DEST_IN &&
                   ml[a] != bus.LR_IN) begin
        emit = 1;
        e_tag[1] = 1'b1;
        e_l = bus.LR_IN ? mdat[a] : bus.DATA_IN;
        e_r = bus.LR_IN ? bus.DATA_IN : mdat[a];
        mv[a] = 0;
        m_occ--;
      end else begin
        emit = 1;
        e_tag[0] = 1'b1;
        e_l = bus.DATA_IN;
        e_r = 0;
        if (m_coll < 65535) m_coll++;
      end
    end
    if (emit) m_send = 1;
    else if (bus.Ack_in) m_send = 0;
  endfunction

  task automatic step();
    #1;
    chk("ack_out", 32'(bus.Ack_out), 32'(model_ack()));
    @(posedge clk);
    model_edge();
    #1;
    chk("send_out", 32'(bus.Send_out), 32'(m_send));
    chk("occ", 32'(occ), 32'(m_occ));
    chk("coll_cnt", 32'(coll), 32'(m_coll));
    if (m_send) begin
      chk("tag_flags", 32'({bus.COLOR_OUT, bus.GEN_OUT,
          bus.DEST_OUT, bus.PAIR_OUT, bus.ERR_OUT}),
          32'(e_tag));
      chk("datal", 32'(bus.DATAL_OUT), 32'(e_l));
      chk("datar", 32'(bus.DATAR_OUT), 32'(e_r));
    end
    @(negedge clk);
  endtask

  typedef struct {
    int snd, del, mat, lr, fl, c, a, data;
    int e_send, e_pair, e_err, e_l, e_r, e_occ, e_coll;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1,0,1,0,0,0,3,'h55, 0,0,0,0,0,1,0};
    tbl[1]  = '{1,0,1,1,0,0,3,'h7F, 1,1,0,'h55,'h7F,0,0};
    tbl[2]  = '{1,0,0,0,0,0,0,'h40, 1,0,0,'h40,0,0,0};
    tbl[3]  = '{1,0,1,0,0,0,5,'h11, 0,0,0,0,0,1,0};
    tbl[4]  = '{1,0,1,0,0,1,5,'h22, 1,0,1,'h22,0,1,1};
    tbl[5]  = '{1,0,1,1,0,0,5,'h33, 1,1,0,'h11,'h33,0,1};
    tbl[6]  = '{1,0,1,0,0,2,3,'h01, 0,0,0,0,0,1,1};
    tbl[7]  = '{1,0,1,0,0,2,4,'h02, 0,0,0,0,0,2,1};
    tbl[8]  = '{1,0,1,0,0,2,5,'h03, 0,0,0,0,0,3,1};
    tbl[9]  = '{1,0,1,0,1,2,6,'h09, 0,0,0,0,0,0,1};
    tbl[10] = '{1,0,1,1,0,2,4,'h04, 0,0,0,0,0,1,1};
    tbl[11] = '{1,1,0,0,0,0,4,'h00, 0,0,0,0,0,0,1};
    tbl[12] = '{1,1,0,0,0,0,4,'h00, 0,0,0,0,0,0,1};
    tbl[13] = '{1,0,1,0,0,3,7,'h05, 0,0,0,0,0,1,1};
    tbl[14] = '{1,0,1,1,0,3,7,'h06, 1,1,0,5,6,0,1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    model_reset();
    #12;
    chk("rst_send", 32'(bus.Send_out), 0);
    chk("rst_ack", 32'(bus.Ack_out), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_coll", 32'(coll), 0);
    chk("rst_flags", 32'({bus.PAIR_OUT, bus.ERR_OUT}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(1'(tbl[i].snd), 1'(tbl[i].del),
            1'(tbl[i].mat), 1'(tbl[i].lr), 3'(tbl[i].c),
            8'd0, 7'd4, 6'(tbl[i].a), 16'(tbl[i].data),
            1'b1, 1'(tbl[i].fl));
      step();
      chk($sformatf("v%0d_send", i),
          32'(bus.Send_out), 32'(tbl[i].e_send));
      chk($sformatf("v%0d_occ", i),
          32'(occ), 32'(tbl[i].e_occ));
      chk($sformatf("v%0d_coll", i),
          32'(coll), 32'(tbl[i].e_coll));
      if (tbl[i].e_send != 0) begin
        chk($sformatf("v%0d_flags", i),
            32'({bus.PAIR_OUT, bus.ERR_OUT}),
            32'({1'(tbl[i].e_pair), 1'(tbl[i].e_err)}));
        chk($sformatf("v%0d_dl", i),
            32'(bus.DATAL_OUT), 32'(tbl[i].e_l));
        chk($sformatf("v%0d_dr", i),
            32'(bus.DATAR_OUT), 32'(tbl[i].e_r));
      end
    end

    // Backpressure: held output, stalled input, resume.
    drive(1, 0, 1, 0, 1, 0, 2, 9, 16'h77, 1, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 16'hA1, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 16'hB2, 0, 0);
    #1;
    chk("bp_ack_low", 32'(bus.Ack_out), 0);
    step();
    chk("bp_hold", 32'(bus.DATAL_OUT), 32'h00A1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 16'hB2, 1, 0);
    #1;
    chk("bp_ack_high", 32'(bus.Ack_out), 1);
    step();
    chk("bp_next", 32'(bus.DATAL_OUT), 32'h00B2);
    chk("bp_send", 32'(bus.Send_out), 1);

    // Asynchronous reset while output is pending.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_send", 32'(bus.Send_out), 0);
    chk("mr_occ", 32'(occ), 0);
    chk("mr_coll", 32'(coll), 0);
    chk("mr_ack", 32'(bus.Ack_out), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1, 1, 1, 0, 2, 9, 16'h78, 1, 0);
    step();
    chk("mr_no_pair", 32'(bus.Send_out), 0);

    for (int k = 0; k < 400; k++) begin
      drive(bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 9) == 0),
            bit'($urandom_range(0, 4) != 0),
            1'($urandom), 3'($urandom_range(0, 1)),
            8'($urandom_range(0, 1)), 7'd2,
            6'($urandom_range(0, 7)), 16'($urandom),
            bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 39) == 0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
